// File: rtl/conv_encoder_k4.sv
// conv_encoder_k4: rate-1/2, constraint-length-4 (8-state) convolutional encoder.
// Every frame starts from state 0 and is flushed with three zero tail bits, so the
// trellis always terminates in state 0.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous reset, active-low
//   enable      low: synchronous abort, hold idle
//   in_valid    input bit valid
//   in_bit      data bit
//   in_last     last data bit of the frame (qualified by in_valid)
//   in_ready    encoder accepts in_bit this cycle
//   out_valid   out_sym is valid
//   out_sym     {p1,p0} code symbol
//   out_last    final tail symbol of the frame
//   out_ready   downstream accepts out_sym
//   busy        high while in DATA or TAIL
//   frame_done  one-cycle pulse when the last tail symbol is handed off
module conv_encoder_k4 #(
    parameter logic [3:0]  G0        = 4'b1111,
    parameter logic [3:0]  G1        = 4'b1101,
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned CNT_W     = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       in_valid,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       in_ready,
    output logic       out_valid,
    output logic [1:0] out_sym,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [1:0] {StIdle, StData, StTail} state_e;

    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(FRAME_LEN - 1);

    state_e           state_q, state_d;
    logic [2:0]       sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       tcnt_q, tcnt_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       out_sym_q, out_sym_d;
    logic             out_last_q, out_last_d;

    logic       can_load;
    logic       accept;
    logic       tail_go;
    logic       term;
    logic       u;
    logic [3:0] window;
    logic [1:0] sym;

    // Output register is free when empty or being drained this cycle.
    assign can_load = !out_valid_q || out_ready;
    assign in_ready = enable && (state_q != StTail) && can_load;
    assign accept   = in_valid && in_ready;
    assign tail_go  = enable && (state_q == StTail) && can_load;

    // In IDLE cnt is 0, so cnt == LastIdx also covers a one-bit FRAME_LEN.
    assign term = in_last || (cnt_q == LastIdx);

    // Tail symbols encode a zero input.
    assign u      = accept ? in_bit : 1'b0;
    assign window = {u, sr_q};
    assign sym    = {^(window & G1), ^(window & G0)};

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        tcnt_d      = tcnt_q;
        out_valid_d = out_valid_q;
        out_sym_d   = out_sym_q;
        out_last_d  = out_last_q;

        if (accept || tail_go) begin
            out_valid_d = 1'b1;
            out_sym_d   = sym;
            out_last_d  = tail_go && (tcnt_q == 2'd2);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    sr_d  = {in_bit, sr_q[2:1]};
                    cnt_d = CntOne;
                    if (term || FRAME_LEN == 1) begin
                        state_d = StTail;
                        tcnt_d  = 2'd0;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    sr_d  = {in_bit, sr_q[2:1]};
                    cnt_d = cnt_q + CntOne;
                    if (term) begin
                        state_d = StTail;
                        tcnt_d  = 2'd0;
                    end
                end
            end
            StTail: begin
                if (tail_go) begin
                    sr_d   = {1'b0, sr_q[2:1]};
                    tcnt_d = tcnt_q + 2'd1;
                    if (tcnt_q == 2'd2) begin
                        // Three zeros have been shifted in, so sr is back to 0.
                        state_d = StIdle;
                        cnt_d   = '0;
                        tcnt_d  = 2'd0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort discards any partial frame; out_sym keeps its last value.
        if (!enable) begin
            state_d     = StIdle;
            sr_d        = 3'd0;
            cnt_d       = '0;
            tcnt_d      = 2'd0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            sr_q        <= 3'd0;
            cnt_q       <= '0;
            tcnt_q      <= 2'd0;
            out_valid_q <= 1'b0;
            out_sym_q   <= 2'd0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            tcnt_q      <= tcnt_d;
            out_valid_q <= out_valid_d;
            out_sym_q   <= out_sym_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_sym    = out_sym_q;
    assign out_last   = out_last_q;
    assign busy       = (state_q != StIdle);
    assign frame_done = out_valid_q && out_ready && out_last_q;

endmodule

// File: tb/tb_conv_encoder_k4.sv
// tb_conv_encoder_k4: directed self-checking bench for conv_encoder_k4 (FRAME_LEN = 4).
// Expected symbols are hand-computed with G0 = 1111, G1 = 1101; each entry is
// {out_last, p1, p0}.
module tb_conv_encoder_k4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b1;
    logic       in_ready;
    logic       out_valid;
    logic [1:0] out_sym;
    logic       out_last;
    logic       busy;
    logic       frame_done;

    conv_encoder_k4 #(
        .FRAME_LEN (4),
        .CNT_W     (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_sym    (out_sym),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [2:0] got_q[$];
    logic [2:0] exp_q[$];
    int         done_cnt = 0;
    bit         bp_on = 1'b0;
    int         bp_idx = 0;
    logic       prev_stall = 1'b0;
    logic [2:0] prev_out = 3'd0;

    // T1 frame: bits 1,0,1,1 -> 11,11,10,11 then tail 10,10,11 (last).
    logic [2:0] exp_t1[7] = '{3'b011, 3'b011, 3'b010, 3'b011, 3'b010, 3'b010, 3'b111};
    // Single-bit frame: 1 -> 11 then tail 11,01,11 (last).
    logic [2:0] exp_t4[4] = '{3'b011, 3'b011, 3'b001, 3'b111};

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: collects every handed-off symbol and checks stall behaviour.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (prev_stall)
                    check("stall_hold", 8'({out_valid, out_last, out_sym}), 8'({1'b1, prev_out}));
                if (out_valid && !out_ready)
                    check("in_ready_stall", 8'(in_ready), 8'd0);
                if (out_valid && out_ready)
                    got_q.push_back({out_last, out_sym});
                if (frame_done)
                    done_cnt++;
            end
            prev_stall = rst && enable && out_valid && !out_ready;
            prev_out   = {out_last, out_sym};
        end
    end

    // Backpressure pattern 1,0,0 repeating.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_on) begin
                out_ready = (bp_idx % 3 == 0);
                bp_idx++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_bit(input logic b, input logic l);
        bit ok = 1'b0;
        int n = 0;
        in_valid = 1'b1;
        in_bit   = b;
        in_last  = l;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        check("bit_accepted", 8'(ok), 8'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_t1();
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
    endtask

    task automatic expect_syms(input string tag);
        int k = 0;
        while (got_q.size() < exp_q.size() && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_count"}, 8'(got_q.size()), 8'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size())
                check($sformatf("%s_sym%0d", tag, i), 8'(got_q[i]), 8'(exp_q[i]));
        end
    endtask

    task automatic clear_obs();
        got_q.delete();
        exp_q.delete();
        done_cnt = 0;
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_out_valid", 8'(out_valid), 8'd0);
        check("rst_out_sym", 8'(out_sym), 8'd0);
        check("rst_out_last", 8'(out_last), 8'd0);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_frame_done", 8'(frame_done), 8'd0);
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b1;
        enable = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", 8'(in_ready), 8'd1);

        // T1: basic frame, one-cycle latency
        clear_obs();
        send_bit(1'b1, 1'b0);
        check("t1_latency_valid", 8'(out_valid), 8'd1);
        check("t1_latency_sym", 8'(out_sym), 8'd3);
        check("t1_busy", 8'(busy), 8'd1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        foreach (exp_t1[i]) exp_q.push_back(exp_t1[i]);
        expect_syms("t1");
        check("t1_done", 8'(done_cnt), 8'd1);
        check("t1_idle", 8'(busy), 8'd0);

        // T2: backpressure
        clear_obs();
        bp_idx = 0;
        bp_on  = 1'b1;
        send_t1();
        foreach (exp_t1[i]) exp_q.push_back(exp_t1[i]);
        expect_syms("t2");
        bp_on     = 1'b0;
        out_ready = 1'b1;
        check("t2_done", 8'(done_cnt), 8'd1);

        // T3: forced termination at FRAME_LEN = 4, next frame from state 0
        clear_obs();
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        foreach (exp_t1[i]) exp_q.push_back(exp_t1[i]);
        exp_q.push_back(3'b011);
        exp_q.push_back(3'b011);
        expect_syms("t3");
        check("t3_done", 8'(done_cnt), 8'd1);
        check("t3_busy_data", 8'(busy), 8'd1);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("t3_abort_busy", 8'(busy), 8'd0);
        enable = 1'b1;

        // T4: single-bit frame
        clear_obs();
        send_bit(1'b1, 1'b1);
        foreach (exp_t4[i]) exp_q.push_back(exp_t4[i]);
        expect_syms("t4");
        check("t4_done", 8'(done_cnt), 8'd1);

        // T5: abort during TAIL after one tail symbol
        clear_obs();
        send_t1();
        @(posedge clk);
        #1;
        check("t5_tail_valid", 8'(out_valid), 8'd1);
        check("t5_tail_sym", 8'(out_sym), 8'd2);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("t5_abort_valid", 8'(out_valid), 8'd0);
        check("t5_abort_last", 8'(out_last), 8'd0);
        check("t5_abort_busy", 8'(busy), 8'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t5_sym_count", 8'(got_q.size()), 8'd5);
        check("t5_no_done", 8'(done_cnt), 8'd0);
        enable = 1'b1;
        clear_obs();
        send_bit(1'b1, 1'b1);
        foreach (exp_t4[i]) exp_q.push_back(exp_t4[i]);
        expect_syms("t5_next");

        // T6: asynchronous reset mid-DATA
        clear_obs();
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("t6_out_valid", 8'(out_valid), 8'd0);
        check("t6_out_sym", 8'(out_sym), 8'd0);
        check("t6_out_last", 8'(out_last), 8'd0);
        check("t6_busy", 8'(busy), 8'd0);
        check("t6_frame_done", 8'(frame_done), 8'd0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        clear_obs();
        send_t1();
        foreach (exp_t1[i]) exp_q.push_back(exp_t1[i]);
        expect_syms("t6");
        check("t6_done", 8'(done_cnt), 8'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
